// File: rtl/snake_game_core.sv
// snake_game_core: game-state engine for a snake on a 16x16 grid (cells are {y,x}).
// Optional macro SNAKE_WRAP_EN: the head wraps at grid edges instead of hitting a wall.
module snake_game_core #(
  parameter int         WIN_LEN    = 15,
  parameter logic [7:0] START_LOC  = 8'h77,
  parameter logic [7:0] START_FOOD = 8'h2A
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Tick,
  input  logic           Start,
  input  logic           Ack,
  input  logic           BtnU,
  input  logic           BtnD,
  input  logic           BtnL,
  input  logic           BtnR,
  output logic           Qi,
  output logic           Qc,
  output logic           Ql,
  output logic           Qw,
  output logic [7:0]     Food,
  output logic [3:0]     Length,
  output logic [127:0]   Locations_Flat
);

  typedef enum logic [1:0] {QI, QC, QL, QW} state_t;
  // Encoding chosen so that the opposite direction is dir ^ 2'b01.
  typedef enum logic [1:0] {DIR_U, DIR_D, DIR_L, DIR_R} dir_t;

  state_t     state, state_n;
  dir_t       dir, dir_n, dir_req;
  logic       req_vld;
  logic [7:0] seg [16];
  logic [3:0] len, len_inc;
  logic [7:0] food, lfsr, nh;
  logic       pending, wall_hit, self_hit, collide, eat, win, overlap, restart;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Next head cell and edge detection
  always_comb begin
    nh       = seg[0];
    wall_hit = 1'b0;
    case (dir)
      DIR_U:   nh[7:4] = seg[0][7:4] - 4'd1;
      DIR_D:   nh[7:4] = seg[0][7:4] + 4'd1;
      DIR_L:   nh[3:0] = seg[0][3:0] - 4'd1;
      default: nh[3:0] = seg[0][3:0] + 4'd1;
    endcase
`ifdef SNAKE_WRAP_EN
    wall_hit = 1'b0;
`else
    case (dir)
      DIR_U:   wall_hit = (seg[0][7:4] == 4'h0);
      DIR_D:   wall_hit = (seg[0][7:4] == 4'hF);
      DIR_L:   wall_hit = (seg[0][3:0] == 4'h0);
      default: wall_hit = (seg[0][3:0] == 4'hF);
    endcase
`endif
  end

  // Body hits for the move, and food-candidate overlap with the live body
  always_comb begin
    eat      = (nh == food) && !pending;
    self_hit = 1'b0;
    overlap  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (4'(i) < len) begin
        if ((seg[i] == nh) && (eat || (4'(i) != len - 4'd1))) self_hit = 1'b1;
        if (seg[i] == lfsr) overlap = 1'b1;
      end
    end
  end

  assign len_inc = len + 4'd1;
  assign collide = wall_hit || self_hit;
  assign win     = eat && (len_inc == 4'(WIN_LEN));
  assign restart = Ack && ((state == QL) || (state == QW));

  always_comb begin
    req_vld = 1'b1;
    dir_req = DIR_R;
    if (BtnU)      dir_req = DIR_U;
    else if (BtnD) dir_req = DIR_D;
    else if (BtnL) dir_req = DIR_L;
    else if (BtnR) dir_req = DIR_R;
    else           req_vld = 1'b0;
    dir_n = dir;
    if (req_vld && !((len > 4'd1) && (dir_req == dir_t'(dir ^ 2'b01)))) dir_n = dir_req;
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= QI;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      QI: if (Start) state_n = QC;
      QC: begin
        if (Tick) begin
          if (collide)  state_n = QL;
          else if (win) state_n = QW;
        end
      end
      QL, QW: if (Ack) state_n = QI;
      default: state_n = QI;
    endcase
  end

  always_comb begin
    Qi = (state == QI);
    Qc = (state == QC);
    Ql = (state == QL);
    Qw = (state == QW);
  end

  // The LFSR survives an Ack restart so successive games see different food.
  always_ff @(posedge Clk) begin
    if (Reset) lfsr <= 8'hB8;
    else       lfsr <= lfsr_step(lfsr);
  end

  always_ff @(posedge Clk) begin
    if (Reset || restart) begin
      len     <= 4'd1;
      seg[0]  <= START_LOC;
      for (int k = 1; k < 16; k++) seg[k] <= 8'h00;
      food    <= START_FOOD;
      dir     <= DIR_R;
      pending <= 1'b0;
    end else begin
      if (pending && !overlap) begin
        food    <= lfsr;
        pending <= 1'b0;
      end
      if (state == QC) begin
        dir <= dir_n;
        if (Tick && !collide) begin
          seg[0] <= nh;
          for (int k = 1; k < 16; k++) seg[k] <= seg[k-1];
          if (eat) begin
            len     <= len_inc;
            pending <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar k = 0; k < 16; k++) begin : g_flat
    assign Locations_Flat[127-8*k -: 8] = seg[k];
  end

  assign Food   = food;
  assign Length = len;

endmodule

// File: tb/tb_snake_game_core.sv
// Directed bench for snake_game_core: one default-parameter instance, plus a
// growth instance and a WIN_LEN=3 instance sharing one stimulus stream.
module tb_snake_game_core;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Reset;
  logic m_tick, m_start, m_ack, m_u, m_d, m_l, m_r;
  logic m_qi, m_qc, m_ql, m_qw;
  logic [7:0] m_food;
  logic [3:0] m_len;
  logic [127:0] m_flat;

  logic g_tick, g_start, g_ack, g_u, g_d, g_l, g_r;
  logic b_qi, b_qc, b_ql, b_qw, w_qi, w_qc, w_ql, w_qw;
  logic [7:0] b_food, w_food;
  logic [3:0] b_len, w_len;
  logic [127:0] b_flat, w_flat;

  snake_game_core u_main (
    .Clk(Clk), .Reset(Reset), .Tick(m_tick), .Start(m_start), .Ack(m_ack),
    .BtnU(m_u), .BtnD(m_d), .BtnL(m_l), .BtnR(m_r),
    .Qi(m_qi), .Qc(m_qc), .Ql(m_ql), .Qw(m_qw),
    .Food(m_food), .Length(m_len), .Locations_Flat(m_flat));

  snake_game_core #(.WIN_LEN(15), .START_FOOD(8'h78)) u_body (
    .Clk(Clk), .Reset(Reset), .Tick(g_tick), .Start(g_start), .Ack(g_ack),
    .BtnU(g_u), .BtnD(g_d), .BtnL(g_l), .BtnR(g_r),
    .Qi(b_qi), .Qc(b_qc), .Ql(b_ql), .Qw(b_qw),
    .Food(b_food), .Length(b_len), .Locations_Flat(b_flat));

  snake_game_core #(.WIN_LEN(3), .START_FOOD(8'h78)) u_win (
    .Clk(Clk), .Reset(Reset), .Tick(g_tick), .Start(g_start), .Ack(g_ack),
    .BtnU(g_u), .BtnD(g_d), .BtnL(g_l), .BtnR(g_r),
    .Qi(w_qi), .Qc(w_qc), .Ql(w_ql), .Qw(w_qw),
    .Food(w_food), .Length(w_len), .Locations_Flat(w_flat));

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] ref_lfsr;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference LFSR in lockstep with every instance (all share Reset).
  always @(posedge Clk) ref_lfsr <= Reset ? 8'hB8 : lfsr_next(ref_lfsr);

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stall so that the next Tick (if it eats) makes the food land on 'want'.
  task automatic wait_lfsr(input logic [7:0] want);
    int n = 0;
    while (lfsr_next(ref_lfsr) != want && n < 300) begin
      cyc();
      n++;
    end
    chk("lfsr_wait", 128'(n < 300), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1;
    {m_tick, m_start, m_ack, m_u, m_d, m_l, m_r} = '0;
    {g_tick, g_start, g_ack, g_u, g_d, g_l, g_r} = '0;
    cyc(); cyc();
    Reset = 1'b0;

    chk("rst_state", 128'({m_qi, m_qc, m_ql, m_qw}), 128'(4'b1000));
    chk("rst_len",   128'(m_len), 128'(1));
    chk("rst_head",  128'(m_flat[127:120]), 128'(8'h77));
    chk("rst_body",  128'(m_flat[119:0]), 128'(0));
    chk("rst_food",  128'(m_food), 128'(8'h2A));
    chk("rst_food_b", 128'(b_food), 128'(8'h78));

    // Start with a simultaneous Tick: state change only
    m_start = 1'b1; m_tick = 1'b1; cyc(); m_start = 1'b0; m_tick = 1'b0;
    chk("start_state", 128'({m_qi, m_qc, m_ql, m_qw}), 128'(4'b0100));
    chk("start_head",  128'(m_flat[127:120]), 128'(8'h77));

    m_tick = 1'b1; repeat (3) cyc(); m_tick = 1'b0;
    chk("right3_head", 128'(m_flat[127:120]), 128'(8'h7A));
    chk("right3_len",  128'(m_len), 128'(1));

    // L with Tick: move still uses right; L takes effect afterwards (Length=1)
    m_l = 1'b1; m_tick = 1'b1; cyc(); m_l = 1'b0; m_tick = 1'b0;
    chk("same_cyc_btn", 128'(m_flat[127:120]), 128'(8'h7B));
    m_tick = 1'b1; cyc(); m_tick = 1'b0;
    chk("len1_reverse", 128'(m_flat[127:120]), 128'(8'h7A));

    m_r = 1'b1; cyc(); m_r = 1'b0;
    m_tick = 1'b1; repeat (5) cyc(); m_tick = 1'b0;
    chk("edge_head", 128'(m_flat[127:120]), 128'(8'h7F));

    m_tick = 1'b1; cyc(); m_tick = 1'b0;
`ifdef SNAKE_WRAP_EN
    chk("wrap_state", 128'({m_qi, m_qc, m_ql, m_qw}), 128'(4'b0100));
    chk("wrap_head",  128'(m_flat[127:120]), 128'(8'h70));
    m_ack = 1'b1; cyc(); m_ack = 1'b0;
    chk("ack_in_qc", 128'({m_qi, m_qc, m_ql, m_qw}), 128'(4'b0100));
`else
    chk("wall_state", 128'({m_qi, m_qc, m_ql, m_qw}), 128'(4'b0010));
    chk("wall_head",  128'(m_flat[127:120]), 128'(8'h7F));
    m_tick = 1'b1; m_u = 1'b1; repeat (3) cyc(); m_tick = 1'b0; m_u = 1'b0;
    chk("lose_frozen", 128'(m_flat[127:120]), 128'(8'h7F));
    chk("lose_state",  128'({m_qi, m_qc, m_ql, m_qw}), 128'(4'b0010));
    m_ack = 1'b1; cyc(); m_ack = 1'b0;
    chk("ack_state", 128'({m_qi, m_qc, m_ql, m_qw}), 128'(4'b1000));
    chk("ack_head",  128'(m_flat[127:120]), 128'(8'h77));
    chk("ack_food",  128'(m_food), 128'(8'h2A));
`endif

    // Reset wins over a Tick in the same cycle
    m_start = 1'b1; cyc(); m_start = 1'b0;
    m_tick = 1'b1; Reset = 1'b1; cyc(); m_tick = 1'b0; Reset = 1'b0;
    chk("rst_over_state", 128'({m_qi, m_qc, m_ql, m_qw}), 128'(4'b1000));
    chk("rst_over_head",  128'(m_flat[127:120]), 128'(8'h77));

    // Growth and win: food at 78, placements steered to 79, 7A, 7B, 0F
    g_start = 1'b1; cyc(); g_start = 1'b0;
    wait_lfsr(8'h79);
    g_tick = 1'b1; cyc(); g_tick = 1'b0;
    chk("eat1_len",  128'(b_len), 128'(2));
    chk("eat1_segs", 128'(b_flat[127:112]), 128'(16'h7877));
    chk("eat1_wlen", 128'(w_len), 128'(2));
    cyc();
    chk("place1_food", 128'(b_food), 128'(8'h79));
    chk("place1_wfood", 128'(w_food), 128'(8'h79));

    g_l = 1'b1; cyc(); g_l = 1'b0;
    wait_lfsr(8'h7A);
    g_tick = 1'b1; cyc(); g_tick = 1'b0;
    chk("len2_no_reverse", 128'(b_flat[127:120]), 128'(8'h79));
    chk("eat2_len",   128'(b_len), 128'(3));
    chk("win_state",  128'({w_qi, w_qc, w_ql, w_qw}), 128'(4'b0001));
    chk("win_segs",   128'(w_flat[127:104]), 128'(24'h797877));
    cyc();
    chk("place2_food", 128'(b_food), 128'(8'h7A));

    wait_lfsr(8'h7B);
    g_tick = 1'b1; cyc(); g_tick = 1'b0;
    chk("eat3_len", 128'(b_len), 128'(4));
    cyc();
    chk("place3_food", 128'(b_food), 128'(8'h7B));

    wait_lfsr(8'h0F);
    g_tick = 1'b1; cyc(); g_tick = 1'b0;
    cyc();
    chk("eat4_len",   128'(b_len), 128'(5));
    chk("eat4_segs",  128'(b_flat[127:88]), 128'(40'h7B7A797877));
    chk("place4_food", 128'(b_food), 128'(8'h0F));
    chk("win_frozen_len",  128'(w_len), 128'(3));
    chk("win_frozen_head", 128'(w_flat[127:120]), 128'(8'h79));

    // U, L, D turns the head back into the body
    g_u = 1'b1; cyc(); g_u = 1'b0; g_tick = 1'b1; cyc(); g_tick = 1'b0;
    g_l = 1'b1; cyc(); g_l = 1'b0; g_tick = 1'b1; cyc(); g_tick = 1'b0;
    chk("turn_segs", 128'(b_flat[127:88]), 128'(40'h6A6B7B7A79));
    g_d = 1'b1; cyc(); g_d = 1'b0; g_tick = 1'b1; cyc(); g_tick = 1'b0;
    chk("self_state", 128'({b_qi, b_qc, b_ql, b_qw}), 128'(4'b0010));
    chk("self_segs",  128'(b_flat[127:88]), 128'(40'h6A6B7B7A79));
    chk("self_len",   128'(b_len), 128'(5));

    g_ack = 1'b1; cyc(); g_ack = 1'b0;
    chk("b_ack_state", 128'({b_qi, b_qc, b_ql, b_qw}), 128'(4'b1000));
    chk("b_ack_len",   128'(b_len), 128'(1));
    chk("b_ack_head",  128'(b_flat[127:120]), 128'(8'h77));
    chk("b_ack_food",  128'(b_food), 128'(8'h78));
    chk("w_ack_state", 128'({w_qi, w_qc, w_ql, w_qw}), 128'(4'b1000));
    chk("w_ack_len",   128'(w_len), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/snake_game_core.md
# snake_game_core

Game-state engine for the snake game. It sits directly upstream of the VGA snake renderer. On every move tick it advances the snake on a 16×16 grid, detects food and collisions, grows the snake, places new food, and sequences the game states. Its outputs (`Qi/Qc/Ql/Qw`, `Food`, `Length`, `Locations_Flat`) are consumed as-is by the renderer in the same `Clk` domain.

## Interface
Parameters:
- `WIN_LEN`, default 15: snake length at which the game is won; legal range 2..15.
- `START_LOC`, default 8'h77: initial head cell, `{y[3:0], x[3:0]}`.
- `START_FOOD`, default 8'h2A: initial food cell.

Ports (one clock; reset is synchronous and active-high):
- `Clk`  in  1: system clock; all state changes on its rising edge.
- `Reset`  in  1: synchronous, active-high; returns the block to initial state.
- `Tick`  in  1: one-cycle move strobe from the game-speed divider.
- `Start`  in  1: leaves the init state.
- `Ack`  in  1: acknowledges a win or loss; returns to init.
- `BtnU`, `BtnD`, `BtnL`, `BtnR`  in  1 each: debounced direction requests.
- `Qi`, `Qc`, `Ql`, `Qw`  out  1 each: one-hot state outputs (init, crawl, lose, win).
- `Food`  out  8: food cell, `{y, x}`.
- `Length`  out  4: current segment count, 1..15.
- `Locations_Flat`  out  128: segment cells; segment 0 (head) is `[127:120]`, segment k is `[127-8k -: 8]`.

## Operation
Reset values:
- State QI (`Qi`=1, others 0).
- `Length`=1; segment 0 = `START_LOC`; all other segments 8'h00.
- `Food`=`START_FOOD`; direction = right; LFSR = 8'hB8; food-pending flag clear.

State machine:
- QI: `Tick` ignored. `Start` → QC.
- QC: moves on each `Tick`.
  - Collision → QL.
  - Length reaches `WIN_LEN` after eating → QW.
- QL / QW: frozen; `Tick` and buttons ignored. `Ack` → QI with all state reinitialized to reset values, except the LFSR, which keeps running.

Direction latch:
- Sampled every cycle in QC.
- Priority U > D > L > R.
- A request exactly opposite the current direction is ignored when `Length` > 1.
- The direction in effect at a `Tick` is the latch value before that cycle's button sample.

Move on `Tick` (QC):
- nh = head + dir: x±1 or y±1, 4-bit fields.
- Eat: nh == `Food` and food-pending clear.
- Self-collision: nh equals any segment i < `Length`, excluding the tail segment (index `Length`-1) when not eating.
- No collision, no eat: segments shift down one (seg[k] ← seg[k-1]), seg[0] ← nh, tail dropped; `Length` unchanged.
- Eat: shift without dropping the tail; `Length` += 1; set food-pending.
  - If the new `Length` == `WIN_LEN`, go to QW; the segments still update.
- Collision: segments and `Length` hold; state → QL.

Food placement:
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every clock in every state.
- While food-pending is set, each cycle compare the LFSR against all live segments.
  - No overlap: `Food` ← LFSR; clear pending.
  - Overlap: retry next cycle.
- `Food` holds its old value while pending.

## Timing
- Outputs are registered and update the cycle after `Tick`; move latency is 1 cycle.
- Food placement completes 1+ cycles after the eat, typically well before the next `Tick`.
- Simultaneous `Tick` and pending food: the move is processed, with eat detection disabled.
- Simultaneous `Start` and `Tick` in QI: the state change only; the first move is on the next `Tick`.
- `Reset` overrides all other inputs in the same cycle, including mid-move and mid-placement.
- `Ack` in QC or QI is ignored; `Start` outside QI is ignored.
- Width rules: x/y arithmetic is mod-16 within nibbles (see Configuration); `Length` never exceeds `WIN_LEN`.

## Configuration
- `SNAKE_WRAP_EN` defined: a head stepping past any edge wraps to the opposite edge (x=15 + right → x=0; y=0 + up → y=15); only self-collision loses.
- `SNAKE_WRAP_EN` undefined: stepping off the grid (x=15 right, x=0 left, y=0 up, y=15 down) is a wall collision → QL, with segments held.

## Test plan
- Reset → `Qi`=1, `Length`=1, `Locations_Flat[127:120]`=8'h77, `Food`=8'h2A, all other segments 0.
- `Start`, then 3 `Tick`s moving right → head 8'h7A, `Length`=1, `Qc`=1; an L press in between with `Length`=1 is honoured; at `Length`=2 it is ignored.
- Head at 8'h7F, `Tick` right → with `SNAKE_WRAP_EN`: head 8'h70, `Qc`=1; without: `Ql`=1, head stays 8'h7F.
- Food at 8'h78, head 8'h77 moving right, `Tick` → `Length`=2, seg0=8'h78, seg1=8'h77; new `Food` ∉ {8'h78, 8'h77} within 20 cycles.
- Length-5 snake steers U, L, D into its own body → `Ql`=1 on that `Tick`; `Ack` → `Qi`=1, `Length`=1.
- `WIN_LEN`=3, eat twice → `Qw`=1 the cycle after the second eat; subsequent `Tick`s change nothing.
